// File: rtl/coin_change_dispenser.sv
// Change payout: returns an amount greedily in 5/2/1 Rs coins over a req/ack hopper handshake.
// Define CHANGE_TIMEOUT_EN to add a hopper ack timeout that parks the block in a sticky FAULT state.
module coin_change_dispenser #(
  parameter int AMT_W       = 5,
  parameter int STOCK_W     = 6,
  parameter int INIT_STOCK  = 10,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             change_valid,
  input  logic [AMT_W-1:0] change_amount,
  output logic             busy,
  output logic             coin_req,
  output logic [1:0]       coin_sel,
  input  logic             hopper_ack,
  input  logic             refill,
  input  logic [1:0]       refill_sel,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remaining,
  output logic             fault
);

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_1    = 2'b01;
  localparam logic [1:0] SEL_2    = 2'b10;
  localparam logic [1:0] SEL_5    = 2'b11;
  localparam logic [STOCK_W-1:0] STOCK_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_REQ,
    S_DONE
`ifdef CHANGE_TIMEOUT_EN
    , S_FAULT
`endif
  } state_e;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               coin_req_q, coin_req_d;
  logic [1:0]         coin_sel_q, coin_sel_d;
  logic               short_q, short_d;
  logic [AMT_W-1:0]   remaining_q, remaining_d;
  logic               settle_q, settle_d;
  logic [STOCK_W-1:0] stock_q [1:3];
  logic [STOCK_W-1:0] stock_d [1:3];
  logic [1:0]         pick;
  logic               ack_take;

  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] sel);
    case (sel)
      SEL_1:   coin_value = AMT_W'(1);
      SEL_2:   coin_value = AMT_W'(2);
      SEL_5:   coin_value = AMT_W'(5);
      default: coin_value = '0;
    endcase
  endfunction

  // Largest coin that fits the amount owed and is still in the hopper.
  always_comb begin
    pick = SEL_NONE;
    if (remaining_q >= AMT_W'(5) && stock_q[3] != '0)      pick = SEL_5;
    else if (remaining_q >= AMT_W'(2) && stock_q[2] != '0) pick = SEL_2;
    else if (remaining_q != '0 && stock_q[1] != '0)        pick = SEL_1;
  end

  // settle_q marks the cycle after an ack: the coin is retired but the hopper gets one idle cycle.
  assign ack_take = (state_q == S_REQ) && !settle_q && hopper_ack;

`ifdef CHANGE_TIMEOUT_EN
  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              fault_q, fault_d;
  logic              timeout;

  assign timeout = (state_q == S_REQ) && !settle_q && !hopper_ack &&
                   (wait_cnt_q == WAIT_W'(ACK_TIMEOUT - 1));
`endif

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (change_valid) state_d = (change_amount != '0) ? S_SELECT : S_DONE;
      S_SELECT: state_d = (pick != SEL_NONE) ? S_REQ : S_DONE;
      S_REQ: begin
        if (settle_q) state_d = S_SELECT;
`ifdef CHANGE_TIMEOUT_EN
        else if (timeout) state_d = S_FAULT;
`endif
      end
      S_DONE:   state_d = S_IDLE;
`ifdef CHANGE_TIMEOUT_EN
      S_FAULT:  state_d = S_FAULT;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    coin_req_d  = (state_d == S_REQ) && !ack_take;
    coin_sel_d  = SEL_NONE;
    if (state_q == S_SELECT) coin_sel_d = pick;
    else if (coin_req_d)     coin_sel_d = coin_sel_q;
    short_d     = short_q;
    remaining_d = remaining_q;
    settle_d    = ack_take;
    if (state_q == S_IDLE && change_valid) begin
      short_d     = 1'b0;
      remaining_d = change_amount;
    end
    if (state_q == S_SELECT && pick == SEL_NONE && remaining_q != '0) short_d = 1'b1;
    if (ack_take) remaining_d = remaining_q - coin_value(coin_sel_q);
    // A refill landing on the same denomination as an ack cancels out.
    for (int k = 1; k <= 3; k++) begin
      stock_d[k] = stock_q[k];
      if (ack_take && coin_sel_q == 2'(k)) begin
        if (!(refill && refill_sel == 2'(k))) stock_d[k] = stock_q[k] - 1'b1;
      end else if (refill && refill_sel == 2'(k) && stock_q[k] != STOCK_MAX) begin
        stock_d[k] = stock_q[k] + 1'b1;
      end
    end
`ifdef CHANGE_TIMEOUT_EN
    wait_cnt_d = (state_q == S_REQ && state_d == S_REQ) ? wait_cnt_q + 1'b1 : '0;
    fault_d    = (state_d == S_FAULT);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      coin_req_q  <= 1'b0;
      coin_sel_q  <= SEL_NONE;
      short_q     <= 1'b0;
      remaining_q <= '0;
      settle_q    <= 1'b0;
      // NOTE: the stock array is three flop counters, not a RAM, so resetting it is legal and wanted.
      for (int k = 1; k <= 3; k++) stock_q[k] <= STOCK_W'(INIT_STOCK);
`ifdef CHANGE_TIMEOUT_EN
      wait_cnt_q  <= '0;
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      coin_req_q  <= coin_req_d;
      coin_sel_q  <= coin_sel_d;
      short_q     <= short_d;
      remaining_q <= remaining_d;
      settle_q    <= settle_d;
      for (int k = 1; k <= 3; k++) stock_q[k] <= stock_d[k];
`ifdef CHANGE_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      fault_q     <= fault_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign coin_req  = coin_req_q;
  assign coin_sel  = coin_sel_q;
  assign short     = short_q;
  assign remaining = remaining_q;
`ifdef CHANGE_TIMEOUT_EN
  assign fault     = fault_q;
`else
  assign fault     = 1'b0;
`endif

endmodule
